// File: rtl/alu_issue_ctrl.sv
// Issue/capture controller for a combinational ALU: accepts one op per valid/ready
// handshake, holds operands on the ALU for SETTLE_CYCLES, then captures Z/HI/LO.
module alu_issue_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [4:0]  OP_MUL        = 5'b01110,
  parameter logic [4:0]  OP_DIV        = 5'b01111
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [4:0]  req_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [4:0]  alu_op,
  input  logic [31:0] alu_hi,
  input  logic [31:0] alu_lo,
  output logic [31:0] z_out,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        done,
  output logic        busy,
  output logic [15:0] op_count
);

  typedef enum logic {IDLE, HOLD} state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  logic [3:0] settle_cnt;

  assign req_ready = (state == IDLE);

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values; done defaults low each cycle to make it a single pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      settle_cnt <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      z_out      <= '0;
      hi_out     <= '0;
      lo_out     <= '0;
      done       <= 1'b0;
      busy       <= 1'b0;
      op_count   <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid && !flush) begin
            alu_a      <= req_a;
            alu_b      <= req_b;
            alu_op     <= req_op;
            settle_cnt <= SETTLE_LOAD;
            busy       <= 1'b1;
            state      <= HOLD;
          end
        end
        HOLD: begin
          // Abort beats capture; operands stay on the ALU for inspection.
          if (flush) begin
            settle_cnt <= '0;
            busy       <= 1'b0;
            state      <= IDLE;
          end else if (settle_cnt != 4'd0) begin
            settle_cnt <= settle_cnt - 4'd1;
          end else begin
            z_out <= alu_lo;
            if (alu_op == OP_MUL || alu_op == OP_DIV) begin
              hi_out <= alu_hi;
              lo_out <= alu_lo;
            end
            op_count <= op_count + 16'd1;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl with a behavioural ALU and a
// transaction-level reference model of the captured results.
module tb_alu_issue_ctrl;

  localparam int unsigned SETTLE = 2;
  localparam logic [4:0] OP_ADD = 5'b00011;
  localparam logic [4:0] OP_SUB = 5'b00100;
  localparam logic [4:0] OP_AND = 5'b00101;
  localparam logic [4:0] OP_OR  = 5'b00110;
  localparam logic [4:0] OP_MUL = 5'b01110;
  localparam logic [4:0] OP_DIV = 5'b01111;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a, req_b;
  logic [4:0]  req_op;
  logic [31:0] alu_a, alu_b;
  logic [4:0]  alu_op;
  logic [31:0] alu_hi, alu_lo;
  logic [31:0] z_out, hi_out, lo_out;
  logic        done, busy;
  logic [15:0] op_count;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [31:0] exp_z, exp_hi, exp_lo;
  logic [15:0] exp_cnt;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ALU: {result_hi, result_lo}
  function automatic logic [63:0] alu_calc(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      OP_ADD:  return {32'd0, a + b};
      OP_SUB:  return {32'd0, a - b};
      OP_AND:  return {32'd0, a & b};
      OP_OR:   return {32'd0, a | b};
      OP_MUL:  return 64'(a) * 64'(b);
      OP_DIV:  return (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      default: return {32'd0, a ^ b};
    endcase
  endfunction

  assign {alu_hi, alu_lo} = alu_calc(alu_op, alu_a, alu_b);

  alu_issue_ctrl #(.SETTLE_CYCLES(SETTLE), .OP_MUL(OP_MUL), .OP_DIV(OP_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_hi(alu_hi), .alu_lo(alu_lo),
    .z_out(z_out), .hi_out(hi_out), .lo_out(lo_out),
    .done(done), .busy(busy), .op_count(op_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_results(input string tag);
    check({tag, ".z"},   z_out,    exp_z);
    check({tag, ".hi"},  hi_out,   exp_hi);
    check({tag, ".lo"},  lo_out,   exp_lo);
    check({tag, ".cnt"}, op_count, exp_cnt);
  endtask

  // Called #1 after a rising edge. flush_at >= 0 aborts in that HOLD cycle.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op,
                       input int flush_at, output int done_cyc);
    int n_busy;
    int budget;
    bit seen;
    bit stable;
    logic [63:0] r;
    n_busy = 0; budget = 0; seen = 0; stable = 1; done_cyc = -1;
    while (!req_ready && budget < 20) begin
      tick();
      budget++;
    end
    check("ready_wait", req_ready, 1'b1);
    req_valid = 1'b1; req_a = a; req_b = b; req_op = op;
    tick();
    req_valid = 1'b0; req_a = $urandom; req_b = $urandom; req_op = 5'($urandom);
    check("done_single", done, 1'b0);
    for (int k = 0; k < 40; k++) begin
      if (done) begin
        seen = 1;
        done_cyc = cyc;
        break;
      end
      if (!busy) break;
      n_busy++;
      if (alu_a !== a || alu_b !== b || alu_op !== op || req_ready !== 1'b0) stable = 0;
      if (k == flush_at) flush = 1'b1;
      tick();
      flush = 1'b0;
    end
    check("done_seen", seen, (flush_at < 0));
    check("busy_cycles", n_busy, (flush_at < 0) ? SETTLE : flush_at + 1);
    check("hold_stable", stable, 1'b1);
    if (flush_at < 0) begin
      r = alu_calc(op, a, b);
      exp_z = r[31:0];
      if (op == OP_MUL || op == OP_DIV) begin
        exp_hi = r[63:32];
        exp_lo = r[31:0];
      end
      exp_cnt = exp_cnt + 16'd1;
      check("ready_in_done", req_ready, 1'b1);
    end else begin
      check("alu_kept", {alu_op, alu_a}, {op, a});
    end
    check_results("op");
  endtask

  task automatic check_zeroed(input string tag);
    check({tag, ".outs"}, {z_out, hi_out}, 64'd0);
    check({tag, ".lo_cnt"}, {lo_out, op_count}, 48'd0);
    check({tag, ".alu"}, {alu_a, alu_b}, 64'd0);
    check({tag, ".ctl"}, {alu_op, done, busy, req_ready}, {5'd0, 1'b0, 1'b0, 1'b1});
  endtask

  initial begin
    int d1, d2, dummy, fa, gap;
    logic [4:0] op;
    logic [4:0] ops [6] = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MUL, OP_DIV};

    rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0;
    req_a = '0; req_b = '0; req_op = '0;
    exp_z = '0; exp_hi = '0; exp_lo = '0; exp_cnt = '0;
    #2;
    check_zeroed("reset");
    req_valid = 1'b1; req_a = 32'd9; req_op = OP_ADD;
    tick();
    check("no_accept_in_reset", busy, 1'b0);
    req_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // Directed sequence from the plan
    issue(32'd15, 32'd10, OP_ADD, -1, d1);
    check("add.z", z_out, 32'd25);
    issue(32'd20, 32'd10, OP_SUB, -1, d2);
    check("b2b.gap", d2 - d1, SETTLE + 1);
    check("sub.z_cnt", {z_out, op_count}, {32'd10, 16'd2});
    issue(32'h0001_0000, 32'h0001_0000, OP_MUL, -1, dummy);
    check("mul.hilo", {hi_out, lo_out, z_out[15:0]}, {32'd1, 32'd0, 16'd0});
    issue(32'd3, 32'd4, OP_ADD, -1, dummy);
    check("add_keeps_hi", hi_out, 32'd1);

    // Flush in the first HOLD cycle, then flush with a request in IDLE
    issue(32'd7, 32'd1, OP_ADD, 0, dummy);
    for (int i = 0; i < 3; i++) begin
      check("flush_no_done", done, 1'b0);
      tick();
    end
    flush = 1'b1; req_valid = 1'b1; req_a = 32'd5; req_b = 32'd5; req_op = OP_ADD;
    tick();
    check("flush_idle_block", {busy, req_ready}, 2'b01);
    check("flush_idle_alu", alu_a, 32'd7);
    flush = 1'b0; req_valid = 1'b0;
    tick();

    // Randomized ops, gaps and flushes
    for (int n = 0; n < 60; n++) begin
      op = ($urandom_range(0, 7) == 0) ? 5'($urandom) : ops[$urandom_range(0, 5)];
      fa = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, SETTLE - 1)) : -1;
      issue($urandom, ($urandom_range(0, 9) == 0) ? 32'd0 : $urandom, op, fa, dummy);
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) tick();
    end

    // Asynchronous reset in the middle of HOLD
    req_valid = 1'b1; req_a = 32'd100; req_b = 32'd200; req_op = OP_ADD;
    tick();
    req_valid = 1'b0;
    check("pre_reset_busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_zeroed("midop_reset");
    exp_z = '0; exp_hi = '0; exp_lo = '0; exp_cnt = '0;
    tick();
    tick();
    check("reset_no_done", done, 1'b0);
    rst_n = 1'b1;
    tick();
    issue(32'd1, 32'd2, OP_ADD, -1, dummy);
    check("after_reset", {z_out, op_count}, {32'd3, 16'd1});

    // Counter wrap: preload near the top, then complete two ops
    force dut.op_count = 16'hFFFE;
    #1;
    release dut.op_count;
    exp_cnt = 16'hFFFE;
    tick();
    issue(32'd11, 32'd22, OP_ADD, -1, dummy);
    check("cnt_ffff", op_count, 16'hFFFF);
    issue(32'd5, 32'd6, OP_MUL, -1, dummy);
    check("cnt_wrap", op_count, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
